fp_minmax_reduce: RTL
=====================

Name: fp_minmax_reduce

Overview:
- Parametrised streaming min/max reduction unit for the FPU. It generalises the single-pair fmax/fmin datapath to arbitrary IEEE-754 exponent/mantissa widths and to vectors of up to MAX_LEN elements.
- It accepts one element per cycle over a valid/ready stream and holds a running accumulator. It returns one result plus an exception flag word per vector.
- It sits beside the scalar FP execution unit and serves vector/loop reductions.

Parameters:
EXP_W, 11, exponent width (8 for single, 11 for double)
MANT_W, 52, stored mantissa width (23 for single, 52 for double)
MAX_LEN, 256, maximum elements per reduction; CNT_W = $clog2(MAX_LEN+1) derived

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  begin a reduction; sampled only in IDLE
op  input  1  0 = min, 1 = max; latched on start
len  input  CNT_W  element count; latched on start; values above MAX_LEN are clamped to MAX_LEN
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid & in_ready
in_data  input  EXP_W+MANT_W+1  element {sign, exponent, mantissa}
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
result  output  EXP_W+MANT_W+1  reduced value
flags  output  5  {NV, DZ, OF, UF, NX}; only NV is ever set
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-low. While reset==0 at a clock edge:
  - state goes to IDLE and the element counter clears to 0.
  - the accumulator clears to 0 and its "accumulator empty" marker is set.
  - in_ready=0, out_valid=0, result=0, flags=0, busy=0.
  - Reset mid-reduction discards all partial state; no result is produced.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: latch op and len (clamped), clear flags, mark accumulator empty.
  - If len==0, go to DONE with result = canonical qNaN; otherwise go to ACC.
- ACC:
  - in_ready=1.
  - On each accepted element: the counter increments and the accumulator updates in the same edge.
  - When the accepted element is the len-th, go to DONE on that edge. out_valid rises the cycle after the last handshake (latency 1).
  - start is ignored outside IDLE.
- DONE:
  - out_valid=1; result and flags are held stable while out_valid & !out_ready.
  - On handshake, go to IDLE. result and flags keep their value until the next start.
  - in_ready=0.
- Accumulator update, with a = accumulator and b = new element:
  - empty accumulator: a <= b, with NaN rules applied as if a were NaN.
  - NaN rules: if both a and b are NaN, the result is canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0). If exactly one is NaN, the result is the other operand.
  - Ordering: -0 < +0. max(+0,-0)=+0 and min(+0,-0)=-0 regardless of order.
  - Compare as sign-magnitude: for negatives, larger magnitude means smaller value.
  - Exactly equal values keep a.
  - Signalling NaN (exponent all ones, mantissa MSB 0, mantissa != 0) in any accepted element sets NV (flags[4]). NV is sticky for the reduction.
  - Subnormals compare by bit pattern; there is no flush.
- Back-pressure: in_valid may drop between elements, and the counter only advances on handshake.

Optional Feature:
FP_REDUCE_INDEX_EN:
- Defined: adds output port result_idx (CNT_W bits), the zero-based position of the element currently selected by the accumulator.
  - Ties keep the earlier index.
  - A canonical-NaN result (all-NaN input or len==0) gives result_idx = 0.
  - result_idx is reset to 0 and is valid and held with out_valid.
- Undefined: the port and its index register are absent; all other behaviour is identical.

Test Plan:
- EXP_W=11, MANT_W=52. op=1, len=3, elements 0x3FF0000000000000, 0xC008000000000000, 0x4000000000000000 -> result 0x4000000000000000, flags 0, out_valid exactly 1 cycle after the 3rd handshake (index 2 if FP_REDUCE_INDEX_EN).
- op=0, len=2, elements 0x0000000000000000, 0x8000000000000000 -> result 0x8000000000000000. Same run with op=1 -> 0x0000000000000000.
- op=1, len=3, elements 0x7FF0000000000001, 0x3FF0000000000000, 0x7FF8000000000000 -> result 0x3FF0000000000000, flags 0x10. All-qNaN input of len 2 -> 0x7FF8000000000000, flags 0.
- len=0 start -> out_valid the next cycle, result 0x7FF8000000000000, flags 0.
- Stalls:
  - Hold out_ready=0 for 5 cycles: result and flags stable, in_ready=0, and start pulses are ignored.
  - in_valid gaps between elements: the same result as the gap-free run.
- Assert reset=0 after 2 of 4 elements accepted -> the next edge gives IDLE with all outputs 0. A new start with len=1 and element 0x40490FDB (EXP_W=8, MANT_W=23 instance) returns 0x40490FDB.

Source files
------------

// File: rtl/fp_minmax_reduce_if.sv
// fp_minmax_reduce_if
// Stream/handshake bundle for the fp_minmax_reduce unit. The signal suffixes
// are written from the reduction unit's point of view.
//   start_i/op_i/len_i          : reduction command (sampled in IDLE)
//   in_valid_i/in_ready_o/in_data_i : element stream
//   out_valid_o/out_ready_i     : result handshake
//   result_o/flags_o            : reduced value and {NV,DZ,OF,UF,NX}
//   busy_o                      : unit is not IDLE
//   result_idx_o                : winning element index (only with FP_REDUCE_INDEX_EN)
// Modports: master = element/command producer, slave = reduction unit.
interface fp_minmax_reduce_if #(
  parameter int unsigned EXP_W   = 11,
  parameter int unsigned MANT_W  = 52,
  parameter int unsigned MAX_LEN = 256
);
  localparam int unsigned DATA_W = EXP_W + MANT_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);

  logic              start_i;
  logic              op_i;
  logic [CNT_W-1:0]  len_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic [4:0]        flags_o;
  logic              busy_o;
`ifdef FP_REDUCE_INDEX_EN
  logic [CNT_W-1:0]  result_idx_o;
`endif

  modport master (
    output start_i, op_i, len_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, flags_o, busy_o
`ifdef FP_REDUCE_INDEX_EN
    , result_idx_o
`endif
  );

  modport slave (
    input  start_i, op_i, len_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, flags_o, busy_o
`ifdef FP_REDUCE_INDEX_EN
    , result_idx_o
`endif
  );
endinterface

// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce
// Streaming IEEE-754 min/max reduction over up to MAX_LEN elements of a
// parametrised format. One element per cycle is folded into a running
// accumulator; one result plus exception flags is returned per vector.
// Ports:
//   clock_i  : clock, rising edge
//   reset_ni : synchronous active-low reset
//   bus      : fp_minmax_reduce_if.slave (command, element stream, result)
// Optional: define FP_REDUCE_INDEX_EN to add bus.result_idx_o, the zero-based
// position of the selected element.
module fp_minmax_reduce #(
  parameter int unsigned EXP_W   = 11,
  parameter int unsigned MANT_W  = 52,
  parameter int unsigned MAX_LEN = 256
) (
  input logic              clock_i,
  input logic              reset_ni,
  fp_minmax_reduce_if.slave bus
);
  localparam int unsigned DATA_W = EXP_W + MANT_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0]  MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  function automatic logic is_nan(input logic [DATA_W-1:0] v);
    return (&v[DATA_W-2:MANT_W]) && (|v[MANT_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [DATA_W-1:0] v);
    return is_nan(v) && !v[MANT_W-1];
  endfunction

  // Sign-magnitude less-than; -0 < +0 falls out of the sign test.
  function automatic logic fp_lt(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    if (x[DATA_W-1] != y[DATA_W-1]) return x[DATA_W-1];
    if (x[DATA_W-1])                return x[DATA_W-2:0] > y[DATA_W-2:0];
    return x[DATA_W-2:0] < y[DATA_W-2:0];
  endfunction

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              empty_q, empty_d;
  logic              nv_q, nv_d;
  logic              op_q, op_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef FP_REDUCE_INDEX_EN
  logic [CNT_W-1:0]  idx_q, idx_d;
`endif

  logic [CNT_W-1:0] len_clamp_c;
  logic             accept_c, last_c;
  logic             a_nan_c, b_nan_c, both_nan_c, take_b_c;

  assign len_clamp_c = (bus.len_i > MAX_LEN_C) ? MAX_LEN_C : bus.len_i;
  assign accept_c    = bus.in_valid_i & in_ready_q;
  assign last_c      = (cnt_q + CNT_W'(1)) == len_q;

  // An empty accumulator behaves like a NaN so the first element is adopted.
  assign a_nan_c    = empty_q | is_nan(acc_q);
  assign b_nan_c    = is_nan(bus.in_data_i);
  assign both_nan_c = a_nan_c & b_nan_c;
  assign take_b_c   = !b_nan_c &
                      (a_nan_c | (op_q ? fp_lt(acc_q, bus.in_data_i)
                                       : fp_lt(bus.in_data_i, acc_q)));

  // State register (handshake outputs registered alongside).
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = (len_clamp_c == '0) ? DONE : ACC;
      ACC:     if (accept_c && last_c) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs come straight from flops.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    unique case (state_d)
      ACC:     begin in_ready_d  = 1'b1; busy_d = 1'b1; end
      DONE:    begin out_valid_d = 1'b1; busy_d = 1'b1; end
      default: ;
    endcase
  end

  // Accumulator, counter and command capture.
  always_comb begin
    acc_d   = acc_q;
    empty_d = empty_q;
    nv_d    = nv_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef FP_REDUCE_INDEX_EN
    idx_d   = idx_q;
`endif
    if (state_q == IDLE && bus.start_i) begin
      op_d    = bus.op_i;
      len_d   = len_clamp_c;
      cnt_d   = '0;
      nv_d    = 1'b0;
      empty_d = 1'b1;
`ifdef FP_REDUCE_INDEX_EN
      idx_d   = '0;
`endif
      if (len_clamp_c == '0) acc_d = QNAN;
    end else if (state_q == ACC && accept_c) begin
      cnt_d   = cnt_q + CNT_W'(1);
      empty_d = 1'b0;
      nv_d    = nv_q | is_snan(bus.in_data_i);
      if (both_nan_c) begin
        acc_d = QNAN;
`ifdef FP_REDUCE_INDEX_EN
        idx_d = '0;
`endif
      end else if (take_b_c) begin
        acc_d = bus.in_data_i;
`ifdef FP_REDUCE_INDEX_EN
        idx_d = cnt_q;
`endif
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      acc_q   <= '0;
      empty_q <= 1'b1;
      nv_q    <= 1'b0;
      op_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef FP_REDUCE_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      empty_q <= empty_d;
      nv_q    <= nv_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef FP_REDUCE_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.result_o    = acc_q;
  assign bus.flags_o     = {nv_q, 4'b0000};
`ifdef FP_REDUCE_INDEX_EN
  assign bus.result_idx_o = idx_q;
`endif
endmodule
